// File: rtl/vga3_pkg.sv
// Shared types and constants for the VGA frame-buffer path.
package vga3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_VIDEO = 1'b0,
    GRANT_HOST  = 1'b1
  } grant_e;

  localparam int unsigned FRAME_BYTES_640X480 = 640 * 480 * 6 / 8;

endpackage

// File: rtl/vbuf_fetch_addr.sv
// Sequential frame fetch address with rewind, increment and end-of-frame flag.
module vbuf_fetch_addr #(
  parameter int unsigned AWIDTH      = 18,
  parameter int unsigned FRAME_BYTES = 230400
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              incr_i,
  output logic [AWIDTH-1:0] addr_o,
  output logic              done_o
);

  localparam int unsigned AW1 = AWIDTH + 1;
  // One spare bit so the counter can sit at FRAME_BYTES == 2^AWIDTH.
  localparam logic [AWIDTH:0] LIMIT = AW1'(FRAME_BYTES);

  logic [AWIDTH:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (clear_i) begin
      addr_d = '0;
    end else if (incr_i && !done_o) begin
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q[AWIDTH-1:0];
  assign done_o = (addr_q >= LIMIT);

endmodule

// File: rtl/vbuf_mem_arbiter.sv
// Frame-buffer SRAM port owner: round-robin between video fetch and host writes.
module vbuf_mem_arbiter
  import vga3_pkg::*;
#(
  parameter int unsigned AWIDTH        = 18,
  parameter int unsigned DWIDTH        = 8,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned FRAME_BYTES   = FRAME_BYTES_640X480
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              FrameStart,
  input  logic              FifoFull,
  output logic [DWIDTH-1:0] ByteOut,
  output logic              ByteStrobe,
  input  logic              HostReq,
  input  logic [AWIDTH-1:0] HostAddr,
  input  logic [DWIDTH-1:0] HostData,
  output logic              HostAck,
  output logic [AWIDTH-1:0] SramAddr,
  output logic [DWIDTH-1:0] SramDataOut,
  input  logic [DWIDTH-1:0] SramDataIn,
  output logic              SramOe,
  output logic              SramWe
);

  localparam int unsigned CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  state_e            state_q, state_d;
  grant_e            last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              kill_q, kill_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic [DWIDTH-1:0] byte_q, byte_d;
  logic              oe_q, oe_d, we_q, we_d, strobe_q, strobe_d, ack_q, ack_d;

  logic [AWIDTH-1:0] fetch_addr;
  logic              fetch_done, fetch_incr;
  logic              vreq, hreq, cnt_last;

  vbuf_fetch_addr #(
    .AWIDTH      (AWIDTH),
    .FRAME_BYTES (FRAME_BYTES)
  ) u_fetch (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .clear_i (FrameStart),
    .incr_i  (fetch_incr),
    .addr_o  (fetch_addr),
    .done_o  (fetch_done)
  );

  assign vreq     = !FifoFull && !fetch_done;
  // A request still high during its own Ack cycle is not the next request yet.
  assign hreq     = HostReq && !ack_q;
  assign cnt_last = (cnt_q == CW'(ACCESS_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    kill_d     = kill_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    byte_d     = byte_q;
    oe_d       = oe_q;
    we_d       = we_q;
    strobe_d   = 1'b0;
    ack_d      = 1'b0;
    fetch_incr = 1'b0;
    case (state_q)
      IDLE: begin
        if (vreq && (!hreq || last_q == GRANT_HOST)) begin
          state_d = READ;
          cnt_d   = '0;
          addr_d  = fetch_addr;
          oe_d    = 1'b1;
          // A rewind in the grant cycle makes this fetch stale as well.
          kill_d  = FrameStart;
        end else if (hreq) begin
          state_d = WRITE;
          cnt_d   = '0;
          addr_d  = HostAddr;
          dout_d  = HostData;
          we_d    = 1'b1;
        end
      end
      READ: begin
        kill_d = kill_q || FrameStart;
        if (cnt_last) begin
          state_d = IDLE;
          last_d  = GRANT_VIDEO;
          oe_d    = 1'b0;
          if (!(kill_q || FrameStart)) begin
            byte_d     = SramDataIn;
            strobe_d   = 1'b1;
            fetch_incr = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        if (cnt_last) begin
          state_d = IDLE;
          last_d  = GRANT_HOST;
          we_d    = 1'b0;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      last_q   <= GRANT_HOST;
      cnt_q    <= '0;
      kill_q   <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      byte_q   <= '0;
      oe_q     <= 1'b0;
      we_q     <= 1'b0;
      strobe_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      kill_q   <= kill_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      byte_q   <= byte_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      strobe_q <= strobe_d;
      ack_q    <= ack_d;
    end
  end

  assign ByteOut     = byte_q;
  assign ByteStrobe  = strobe_q;
  assign HostAck     = ack_q;
  assign SramAddr    = addr_q;
  assign SramDataOut = dout_q;
  assign SramOe      = oe_q;
  assign SramWe      = we_q;

endmodule

// File: tb/tb_vbuf_mem_arbiter.sv
// Directed self-checking bench for vbuf_mem_arbiter (8-byte frame).
module tb_vbuf_mem_arbiter;

  logic        Clk, Reset, FrameStart, FifoFull, HostReq;
  logic [17:0] HostAddr, SramAddr;
  logic [7:0]  HostData, ByteOut, SramDataOut, SramDataIn;
  logic        ByteStrobe, HostAck, SramOe, SramWe;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned overlap = 0;
  int unsigned oe_cnt = 0;
  logic [7:0]  bytes_q[$];
  int unsigned scyc_q[$];

  vbuf_mem_arbiter #(
    .AWIDTH        (18),
    .DWIDTH        (8),
    .ACCESS_CYCLES (2),
    .FRAME_BYTES   (8)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .FrameStart  (FrameStart),
    .FifoFull    (FifoFull),
    .ByteOut     (ByteOut),
    .ByteStrobe  (ByteStrobe),
    .HostReq     (HostReq),
    .HostAddr    (HostAddr),
    .HostData    (HostData),
    .HostAck     (HostAck),
    .SramAddr    (SramAddr),
    .SramDataOut (SramDataOut),
    .SramDataIn  (SramDataIn),
    .SramOe      (SramOe),
    .SramWe      (SramWe)
  );

  // SRAM content model: each location holds the low byte of its address.
  assign SramDataIn = SramAddr[7:0];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
    if (ByteStrobe) begin
      bytes_q.push_back(ByteOut);
      scyc_q.push_back(cyc);
    end
    if (SramOe && SramWe) overlap++;
    if (SramOe) oe_cnt++;
  endtask

  logic        we_a[1:9], oe_a[1:9], ack_a[1:9];
  logic [17:0] addr_a[1:9];
  logic [7:0]  dout_a[1:9];
  int unsigned n, first_ack;
  logic        found;

  initial begin
    Reset = 1'b1; FrameStart = 1'b0; FifoFull = 1'b0;
    HostReq = 1'b0; HostAddr = '0; HostData = '0;

    step();
    step();
    check("reset_outs", {SramOe, SramWe, ByteStrobe, HostAck, ByteOut, SramAddr, SramDataOut}, '0);

    // Streaming: strobes at cycles 3, 6, 9 carrying 0, 1, 2.
    Reset = 1'b0;
    cyc = 0;
    bytes_q.delete(); scyc_q.delete();
    step();
    check("first_oe", {SramOe, SramAddr}, {1'b1, 18'h0});
    for (int i = 0; i < 8; i++) step();
    check("stream_n", bytes_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < bytes_q.size()) begin
        check("stream_byte", bytes_q[i], i);
        check("stream_cyc", scyc_q[i], 3 * (i + 1));
      end
    end

    // FifoFull throttles fetches; resumes at the next byte.
    FifoFull = 1'b1;
    oe_cnt = 0;
    bytes_q.delete(); scyc_q.delete();
    for (int i = 0; i < 10; i++) step();
    check("full_oe", oe_cnt, 0);
    check("full_strobe", bytes_q.size(), 0);
    FifoFull = 1'b0;
    cyc = 0; oe_cnt = 0;
    for (int i = 0; i < 30; i++) step();
    check("resume_n", bytes_q.size(), 5);
    if (bytes_q.size() == 5) begin
      check("resume_first", bytes_q[0], 3);
      check("resume_last", bytes_q[4], 7);
      check("resume_cyc", scyc_q[0], 3);
    end
    check("frame_end_oe", oe_cnt, 10);

    // FrameStart rewinds the finished frame.
    FrameStart = 1'b1;
    step();
    FrameStart = 1'b0;
    step(); step(); step();
    check("restart_strobe", {ByteStrobe, ByteOut}, {1'b1, 8'h00});

    // Host write against continuous video demand.
    HostReq = 1'b1; HostAddr = 18'h00100; HostData = 8'hA5;
    first_ack = 0;
    for (int unsigned k = 1; k <= 9; k++) begin
      step();
      we_a[k] = SramWe; oe_a[k] = SramOe; ack_a[k] = HostAck;
      addr_a[k] = SramAddr; dout_a[k] = SramDataOut;
      if (HostAck && first_ack == 0) first_ack = k;
    end
    HostReq = 1'b0;
    check("ack_latency", first_ack, 3);
    n = 0;
    for (int unsigned k = 1; k <= 3; k++)
      if (we_a[k] && addr_a[k] == 18'h00100 && dout_a[k] == 8'hA5) n++;
    check("we_cycles", n, 2);
    check("alt_read", {oe_a[4], we_a[4], addr_a[4]}, {1'b1, 1'b0, 18'h1});
    check("alt_write", {we_a[7], we_a[8], we_a[9]}, 3'b110);
    check("second_ack", {ack_a[3], ack_a[4], ack_a[9]}, 3'b101);

    // FrameStart during the second READ cycle of address 5.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (SramOe && SramAddr == 18'h5) found = 1'b1;
    end
    check("wait_addr5", found, 1'b1);
    step();
    FrameStart = 1'b1;
    step();
    FrameStart = 1'b0;
    check("kill_strobe", {ByteStrobe, SramOe, ByteOut}, {1'b0, 1'b0, 8'h04});
    step();
    check("refetch_addr", {SramOe, SramAddr}, {1'b1, 18'h0});
    step(); step();
    check("refetch_byte", {ByteStrobe, ByteOut}, {1'b1, 8'h00});

    // Reset in the middle of a write.
    HostReq = 1'b1; HostAddr = 18'h3FFFF; HostData = 8'h5A;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (SramWe) found = 1'b1;
    end
    check("wait_write", found, 1'b1);
    Reset = 1'b1;
    #1;
    check("async_reset", {SramWe, SramOe, ByteStrobe, HostAck}, 4'b0000);
    step();
    Reset = 1'b0;
    step();
    check("tie_to_video", {SramOe, SramWe, SramAddr}, {1'b1, 1'b0, 18'h0});
    HostReq = 1'b0;
    step(); step();

    check("oe_we_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
